// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
//   Shared definitions for the execute stage: ALUOp encodings, the MUL/DIV
//   sequencer state encoding, the internal MUL/DIV operation code and the
//   "no destination" register index. Imported by ex_stage and muldiv_iter.
package ex_stage_pkg;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_NOR   = 5'd5;
    localparam logic [4:0] ALU_SLL   = 5'd6;
    localparam logic [4:0] ALU_SRL   = 5'd7;
    localparam logic [4:0] ALU_SRA   = 5'd8;
    localparam logic [4:0] ALU_SLT   = 5'd9;
    localparam logic [4:0] ALU_SLTU  = 5'd10;
    localparam logic [4:0] ALU_LUI   = 5'd11;
    localparam logic [4:0] ALU_LINK  = 5'd12;
    localparam logic [4:0] ALU_MUL   = 5'd16;
    localparam logic [4:0] ALU_MULHU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;
    localparam logic [4:0] ALU_REM   = 5'd20;
    localparam logic [4:0] ALU_REMU  = 5'd21;

    // Register index 0 is the hard-wired zero register: writing it is a no-op.
    localparam int REG_ZERO = 0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Ordered so that ALUOp[2:0] of opcodes 16..21 maps directly onto it.
    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULHU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_REM   = 3'd4,
        MD_REMU  = 3'd5
    } md_op_e;

    // Single-cycle ALU opcodes occupy the contiguous range 0..12.
    function automatic logic op_is_single(input logic [4:0] op);
        return op <= ALU_LINK;
    endfunction

endpackage

// File: rtl/ex_stage_muldiv_iter.sv
// muldiv_iter
//   Iterative radix-2 multiply / divide unit, one bit per clock (falling edge).
//   Multiply is shift-add (low or high word of the unsigned product; the low
//   word is identical for signed operands). Divide is restoring division on
//   operand magnitudes with a sign fix-up applied to the final step's output.
//   Divide by zero yields an all-ones quotient and remainder = dividend.
//   Only built when LAPIDO_MULDIV_EN is defined.
// Ports
//   clock    in   falling-edge clock
//   reset_n  in   asynchronous active-low reset (iteration counter only)
//   start    in   latch operands and operation, restart the counter
//   en       in   perform one iteration this cycle
//   op       in   md_op_e operation
//   op_a     in   DATA_W  multiplicand / dividend
//   op_b     in   DATA_W  multiplier / divisor
//   done     out  this cycle performs the last iteration; result is valid
//   result   out  DATA_W  fixed-up result of the current iteration
`ifdef LAPIDO_MULDIV_EN
module muldiv_iter
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              en,
    input  md_op_e            op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int               CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;    // product high word / partial remainder
    logic [DATA_W-1:0] sh_q, sh_d;      // product low word / dividend-quotient
    logic [DATA_W-1:0] opnd_q, opnd_d;  // multiplicand / divisor magnitude
    logic              is_div_q, is_div_d;
    logic              sel_hi_q, sel_hi_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;

    logic [DATA_W-1:0] acc_n, sh_n, quo, rem;
    logic [DATA_W:0]   sum, shifted, diff;
    logic              is_div, is_signed, neg_a, neg_b;

    function automatic logic [DATA_W-1:0] negate_if(input logic neg,
                                                    input logic [DATA_W-1:0] v);
        return neg ? -v : v;
    endfunction

    // One iteration, evaluated combinationally so the last step's result can
    // be captured by the consumer on the same edge that completes it.
    always_comb begin
        sum     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        shifted = {acc_q, sh_q[DATA_W-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (is_div_q) begin
            // diff[DATA_W] is the borrow: set means the divisor did not fit.
            if (!diff[DATA_W]) begin
                acc_n = diff[DATA_W-1:0];
                sh_n  = {sh_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_n = shifted[DATA_W-1:0];
                sh_n  = {sh_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_n = sum[DATA_W:1];
            sh_n  = {sum[0], sh_q[DATA_W-1:1]};
        end
        quo = div0_q ? '1 : negate_if(neg_quo_q, sh_n);
        rem = negate_if(neg_rem_q, acc_n);
        if (is_div_q) begin
            result = sel_hi_q ? rem : quo;
        end else begin
            result = sel_hi_q ? acc_n : sh_n;
        end
    end

    assign done = en && (cnt_q == LAST);

    always_comb begin
        is_div    = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
        is_signed = (op == MD_DIV) || (op == MD_REM);
        neg_a     = is_signed & op_a[DATA_W-1];
        neg_b     = is_signed & op_b[DATA_W-1];

        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        sel_hi_d  = sel_hi_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        if (start) begin
            cnt_d     = '0;
            acc_d     = '0;
            sh_d      = is_div ? negate_if(neg_a, op_a) : op_b;
            opnd_d    = is_div ? negate_if(neg_b, op_b) : op_a;
            is_div_d  = is_div;
            sel_hi_d  = (op == MD_MULHU) || (op == MD_REM) || (op == MD_REMU);
            neg_quo_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            div0_d    = (op_b == '0);
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = acc_n;
            sh_d  = sh_n;
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Datapath state is always reloaded by start, so it needs no reset.
    always_ff @(negedge clock) begin
        acc_q     <= acc_d;
        sh_q      <= sh_d;
        opnd_q    <= opnd_d;
        is_div_q  <= is_div_d;
        sel_hi_q  <= sel_hi_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        div0_q    <= div0_d;
    end

endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage
//   Execute stage between the ID/EX and EX/MEM pipeline registers. Computes
//   the single-cycle ALU result and registers it with the memory controls into
//   the EX/MEM slot on the falling clock edge. With LAPIDO_MULDIV_EN defined,
//   opcodes 16..21 run on the iterative muldiv_iter unit: the stage stalls
//   upstream and emits bubbles until the result is written DATA_W edges after
//   the op was accepted. Without the macro those opcodes are illegal and
//   stall is tied low.
// Ports
//   clock, reset_n                  falling-edge clock, async active-low reset
//   valid_in, flush                 live instruction / kill in-flight work
//   registerFileDataA/B             operands (B also store data)
//   extendedSignal, aluSrc          immediate and B-operand select
//   pcpp                            PC+4 link value
//   ALUOp                           5-bit operation code
//   registerFileWrite               destination register (0 = none)
//   memRead, memWrite, memToReg     memory controls, passed through
//   stall                           combinational upstream hold
//   aluResult_out, storeData_out, regDest_out, memRead_out, memWrite_out,
//   memToReg_out, valid_out, illegalOp   registered EX/MEM slot
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     registerFileDataA,
    input  logic [DATA_W-1:0]     registerFileDataB,
    input  logic [DATA_W-1:0]     extendedSignal,
    input  logic [DATA_W-1:0]     pcpp,
    input  logic                  aluSrc,
    input  logic [4:0]            ALUOp,
    input  logic [REG_ADDR_W-1:0] registerFileWrite,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  memToReg,
    output logic                  stall,
    output logic [DATA_W-1:0]     aluResult_out,
    output logic [DATA_W-1:0]     storeData_out,
    output logic [REG_ADDR_W-1:0] regDest_out,
    output logic                  memRead_out,
    output logic                  memWrite_out,
    output logic                  memToReg_out,
    output logic                  valid_out,
    output logic                  illegalOp
);

    localparam int SHAMT_W = $clog2(DATA_W);

    function automatic logic [DATA_W-1:0] alu_calc(input logic [4:0]        op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] link);
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic [SHAMT_W-1:0]       shamt;
        a_s   = $signed(a);
        b_s   = $signed(b);
        shamt = b[SHAMT_W-1:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLL:  return a << shamt;
            ALU_SRL:  return a >> shamt;
            ALU_SRA:  return a_s >>> shamt;
            ALU_SLT:  return (a_s < b_s) ? DATA_W'(1) : '0;
            ALU_SLTU: return (a < b) ? DATA_W'(1) : '0;
            ALU_LUI:  return b << 16;
            ALU_LINK: return link;
            default:  return '0;
        endcase
    endfunction

    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     alu_out;
    logic                  is_md;
    logic                  op_legal;

    logic [DATA_W-1:0]     alu_result_q, alu_result_d;
    logic [DATA_W-1:0]     store_data_q, store_data_d;
    logic [REG_ADDR_W-1:0] reg_dest_q, reg_dest_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic                  valid_q, valid_d;
    logic                  illegal_q, illegal_d;

`ifdef LAPIDO_MULDIV_EN
    md_state_e             state_q, state_d;
    logic                  md_start;
    logic                  md_done;
    logic [DATA_W-1:0]     md_result;
    // Instruction fields captured when the MUL/DIV op is accepted, so that
    // upstream may change freely while the unit iterates.
    logic [DATA_W-1:0]     md_store_q, md_store_d;
    logic [REG_ADDR_W-1:0] md_rd_q, md_rd_d;
    logic                  md_mem_read_q, md_mem_read_d;
    logic                  md_mem_write_q, md_mem_write_d;
    logic                  md_mem_to_reg_q, md_mem_to_reg_d;

    assign is_md = (ALUOp >= ALU_MUL) && (ALUOp <= ALU_REMU);
    assign stall = ((state_q == MD_IDLE) && valid_in && is_md) || (state_q == MD_BUSY);

    muldiv_iter #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (md_start),
        .en      (state_q == MD_BUSY),
        .op      (md_op_e'(ALUOp[2:0])),
        .op_a    (registerFileDataA),
        .op_b    (op_b),
        .done    (md_done),
        .result  (md_result)
    );
`else
    assign is_md = 1'b0;
    assign stall = 1'b0;
`endif

    assign op_b     = aluSrc ? extendedSignal : registerFileDataB;
    assign alu_out  = alu_calc(ALUOp, registerFileDataA, op_b, pcpp);
    assign op_legal = op_is_single(ALUOp) || is_md;

    always_comb begin
        // Data fields hold when the slot goes empty; controls always clear.
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        reg_dest_d   = reg_dest_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        valid_d      = 1'b0;
        illegal_d    = 1'b0;
`ifdef LAPIDO_MULDIV_EN
        state_d         = state_q;
        md_start        = 1'b0;
        md_store_d      = md_store_q;
        md_rd_d         = md_rd_q;
        md_mem_read_d   = md_mem_read_q;
        md_mem_write_d  = md_mem_write_q;
        md_mem_to_reg_d = md_mem_to_reg_q;
`endif

        if (flush) begin
            // Kill both the EX/MEM slot and any iteration in progress; an
            // instruction presented in the same cycle is discarded.
`ifdef LAPIDO_MULDIV_EN
            state_d = MD_IDLE;
`endif
        end
`ifdef LAPIDO_MULDIV_EN
        else if (state_q == MD_BUSY) begin
            if (md_done) begin
                state_d      = MD_IDLE;
                alu_result_d = md_result;
                store_data_d = md_store_q;
                reg_dest_d   = md_rd_q;
                mem_read_d   = md_mem_read_q;
                mem_write_d  = md_mem_write_q;
                mem_to_reg_d = md_mem_to_reg_q;
                valid_d      = 1'b1;
            end
        end
`endif
        else if (valid_in) begin
            if (!op_legal) begin
                alu_result_d = '0;
                store_data_d = registerFileDataB;
                reg_dest_d   = REG_ADDR_W'(REG_ZERO);
                valid_d      = 1'b1;
                illegal_d    = 1'b1;
            end
`ifdef LAPIDO_MULDIV_EN
            else if (is_md) begin
                md_start        = 1'b1;
                state_d         = MD_BUSY;
                md_store_d      = registerFileDataB;
                md_rd_d         = registerFileWrite;
                md_mem_read_d   = memRead;
                md_mem_write_d  = memWrite;
                md_mem_to_reg_d = memToReg;
            end
`endif
            else begin
                alu_result_d = alu_out;
                store_data_d = registerFileDataB;
                reg_dest_d   = registerFileWrite;
                mem_read_d   = memRead;
                mem_write_d  = memWrite;
                mem_to_reg_d = memToReg;
                valid_d      = 1'b1;
            end
        end
    end

    // EX/MEM boundary
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            reg_dest_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            reg_dest_q   <= reg_dest_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            valid_q      <= valid_d;
            illegal_q    <= illegal_d;
        end
    end

`ifdef LAPIDO_MULDIV_EN
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= MD_IDLE;
            md_store_q      <= '0;
            md_rd_q         <= '0;
            md_mem_read_q   <= 1'b0;
            md_mem_write_q  <= 1'b0;
            md_mem_to_reg_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            md_store_q      <= md_store_d;
            md_rd_q         <= md_rd_d;
            md_mem_read_q   <= md_mem_read_d;
            md_mem_write_q  <= md_mem_write_d;
            md_mem_to_reg_q <= md_mem_to_reg_d;
        end
    end
`endif

    assign aluResult_out = alu_result_q;
    assign storeData_out = store_data_q;
    assign regDest_out   = reg_dest_q;
    assign memRead_out   = mem_read_q;
    assign memWrite_out  = mem_write_q;
    assign memToReg_out  = mem_to_reg_q;
    assign valid_out     = valid_q;
    assign illegalOp     = illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
//   Directed-vector bench for ex_stage. Inputs change just after the rising
//   edge; the DUT updates on the falling edge; outputs are sampled 1 time
//   unit after the following rising edge. MUL/DIV vectors are included when
//   LAPIDO_MULDIV_EN is defined, otherwise opcode 16 is checked as illegal.
module tb_ex_stage;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_NOR = 5'd5,  OP_SLL = 5'd6,  OP_SRL = 5'd7;
    localparam logic [4:0] OP_SRA = 5'd8,  OP_SLT = 5'd9,  OP_SLTU = 5'd10, OP_LUI = 5'd11;
    localparam logic [4:0] OP_LINK = 5'd12, OP_MUL = 5'd16, OP_MULHU = 5'd17, OP_DIV = 5'd18;
    localparam logic [4:0] OP_DIVU = 5'd19, OP_REM = 5'd20;

    logic        clock = 1'b0;
    logic        reset_n, valid_in, flush, aluSrc;
    logic [31:0] registerFileDataA, registerFileDataB, extendedSignal, pcpp;
    logic [4:0]  ALUOp, registerFileWrite;
    logic        memRead, memWrite, memToReg;
    logic        stall;
    logic [31:0] aluResult_out, storeData_out;
    logic [4:0]  regDest_out;
    logic        memRead_out, memWrite_out, memToReg_out, valid_out, illegalOp;

    int n_total = 0;
    int n_bad   = 0;

    ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .valid_in          (valid_in),
        .flush             (flush),
        .registerFileDataA (registerFileDataA),
        .registerFileDataB (registerFileDataB),
        .extendedSignal    (extendedSignal),
        .pcpp              (pcpp),
        .aluSrc            (aluSrc),
        .ALUOp             (ALUOp),
        .registerFileWrite (registerFileWrite),
        .memRead           (memRead),
        .memWrite          (memWrite),
        .memToReg          (memToReg),
        .stall             (stall),
        .aluResult_out     (aluResult_out),
        .storeData_out     (storeData_out),
        .regDest_out       (regDest_out),
        .memRead_out       (memRead_out),
        .memWrite_out      (memWrite_out),
        .memToReg_out      (memToReg_out),
        .valid_out         (valid_out),
        .illegalOp         (illegalOp)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic mtr, input logic v);
        ALUOp             = op;
        registerFileDataA = a;
        registerFileDataB = b;
        extendedSignal    = imm;
        aluSrc            = src;
        registerFileWrite = rd;
        memRead           = mr;
        memWrite          = mw;
        memToReg          = mtr;
        valid_in          = v;
    endtask

    task automatic alu1(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        drive(op, a, b, 32'h0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk(tag, aluResult_out, exp);
    endtask

`ifdef LAPIDO_MULDIV_EN
    // Presents one MUL/DIV op for a single cycle, then scrambles the inputs
    // with valid_in low while the stage iterates. Counts stall-high cycles.
    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int   cyc;
        logic bubble_ok;
        drive(op, a, b, 32'h0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        cyc       = 0;
        bubble_ok = 1'b1;
        while (stall && cyc < 40) begin
            cyc++;
            tick();
            if (cyc == 1) drive(OP_ADD, 32'h5555, 32'h0, 32'h0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            if (stall && valid_out) bubble_ok = 1'b0;
        end
        chk({tag, "_stall_cycles"}, cyc, 33);
        chk({tag, "_result"}, aluResult_out, exp);
        chk({tag, "_valid"}, valid_out, 1);
        chk({tag, "_rd"}, regDest_out, 3);
        chk({tag, "_bubbles"}, bubble_ok, 1);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        pcpp    = 32'h0000_0400;
        drive(OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        // Reset state
        chk("rst_result", aluResult_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_stall", stall, 0);
        chk("rst_illegal", illegalOp, 0);
        chk("rst_rd", regDest_out, 0);
        reset_n = 1'b1;

        alu1("add_3_4", OP_ADD, 32'd3, 32'd4, 32'd7);
        chk("add_valid", valid_out, 1);
        chk("add_rd", regDest_out, 1);

        // Asynchronous reset mid-run, between clock edges
        drive(OP_ADD, 32'd10, 32'd20, 32'h0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("pre_rst_result", aluResult_out, 30);
        chk("pre_rst_memwrite", memWrite_out, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_result", aluResult_out, 0);
        chk("async_rst_valid", valid_out, 0);
        chk("async_rst_rd", regDest_out, 0);
        chk("async_rst_memwrite", memWrite_out, 0);
        chk("async_rst_stall", stall, 0);
        reset_n = 1'b1;
        alu1("post_rst_add", OP_ADD, 32'd3, 32'd4, 32'd7);

        // ALU operations
        alu1("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu1("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu1("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu1("or", OP_OR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
        alu1("xor", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        alu1("nor", OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF);
        alu1("sll_amt_low5", OP_SLL, 32'h1, 32'h21, 32'h2);
        alu1("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu1("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu1("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
        alu1("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu1("lui", OP_LUI, 32'h0, 32'h1234, 32'h1234_0000);
        alu1("link", OP_LINK, 32'h0, 32'h0, 32'h0000_0400);

        // Immediate operand with load controls
        drive(OP_ADD, 32'h100, 32'hDEAD, 32'hFFFF_FFFC, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("imm_result", aluResult_out, 32'hFC);
        chk("imm_memread", memRead_out, 1);
        chk("imm_memtoreg", memToReg_out, 1);
        chk("imm_rd", regDest_out, 5);
        chk("imm_storedata", storeData_out, 32'hDEAD);

        // Invalid slot: controls must not leak through
        drive(OP_ADD, 32'h1, 32'h1, 32'h0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("inv_valid", valid_out, 0);
        chk("inv_memread", memRead_out, 0);
        chk("inv_memwrite", memWrite_out, 0);

        // Illegal opcode: one-cycle pulse, no memory side effects
        drive(5'd31, 32'h1, 32'h2, 32'h0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("ill31_pulse", illegalOp, 1);
        chk("ill31_valid", valid_out, 1);
        chk("ill31_memwrite", memWrite_out, 0);
        chk("ill31_rd", regDest_out, 0);
        chk("ill31_result", aluResult_out, 0);
        alu1("after_ill_add", OP_ADD, 32'd1, 32'd1, 32'd2);
        chk("ill31_pulse_end", illegalOp, 0);
        drive(5'd13, 32'h1, 32'h2, 32'h0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ill13_pulse", illegalOp, 1);

        // Flush with a valid instruction in the same cycle discards it
        drive(OP_ADD, 32'd8, 32'd8, 32'h0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", valid_out, 0);
        chk("flush_memwrite", memWrite_out, 0);
        chk("flush_illegal", illegalOp, 0);

`ifdef LAPIDO_MULDIV_EN
        run_md("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_md("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_md("divu_by0", OP_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF);
        run_md("div_m7_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_md("rem_m7_by0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_md("mul_6_7", OP_MUL, 32'd6, 32'd7, 32'd42);
        run_md("mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
        run_md("mulhu_ones", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Flush a MUL at iteration 10
        drive(OP_MUL, 32'd6, 32'd7, 32'h0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        #1;
        chk("mulflush_stall_before", stall, 1);
        tick();
        flush = 1'b0;
        #1;
        chk("mulflush_valid", valid_out, 0);
        chk("mulflush_stall_after", stall, 0);
        alu1("mulflush_next_add", OP_ADD, 32'd3, 32'd4, 32'd7);
        chk("mulflush_next_valid", valid_out, 1);

        // Reset while BUSY
        drive(OP_DIV, 32'd100, 32'd3, 32'h0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        chk("busy_rst_stall", stall, 0);
        chk("busy_rst_valid", valid_out, 0);
        reset_n = 1'b1;
        alu1("busy_rst_next_add", OP_ADD, 32'd3, 32'd4, 32'd7);
`else
        // Without the MUL/DIV unit, opcode 16 is illegal and never stalls
        drive(OP_MUL, 32'd6, 32'd7, 32'h0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("ill16_stall", stall, 0);
        tick();
        chk("ill16_pulse", illegalOp, 1);
        chk("ill16_memwrite", memWrite_out, 0);
        chk("ill16_rd", regDest_out, 0);
        chk("ill16_valid", valid_out, 1);
        alu1("after_ill16_add", OP_ADD, 32'd3, 32'd4, 32'd7);
        chk("ill16_pulse_end", illegalOp, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
